// File: rtl/arcade_input_hub.sv
// arcade_input_hub: merges keyboard, USB and DB joysticks into active-low player controls, with coin stretch, pause detect and config capture
module arcade_input_hub #(
  parameter int PLAYERS = 2,
  parameter int BUTTONS = 3,
  parameter int DIP_BANKS = 3,
  parameter logic [23:0] COIN_MIN = 24'd4_900_000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic [10:0] ps2_key,
  input  logic [16*PLAYERS-1:0] joy_usb,
  input  logic [31:0] joy_db,
  input  logic [1:0] joy_db_ena,
  input  logic ioctl_wr,
  input  logic [7:0] ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0] ioctl_dout,
  output logic [4*PLAYERS-1:0] p_dir,
  output logic [BUTTONS*PLAYERS-1:0] p_btn,
  output logic [PLAYERS-1:0] p_start,
  output logic [PLAYERS-1:0] p_coin,
  output logic service,
  output logic pause_pulse,
  output logic [8*DIP_BANKS-1:0] dipsw,
  output logic [7:0] cfg_flags
);
  logic prime, old_state, key_ev, pause_prev;
  logic [15:0] keys, hit;
  logic [8:0] kbtn;
  logic [4*PLAYERS-1:0] dir_h;
  logic [BUTTONS*PLAYERS-1:0] btn_h;
  logic [PLAYERS-1:0] start_h, coin_h, pause_h, coin_prev, last_src;
  logic [23:0] cnt [PLAYERS];
  logic unused;
  assign unused = ^{ps2_key[8], keys};
  assign key_ev = !prime && (ps2_key[10] != old_state);
  assign kbtn = {6'b0, keys[15:13]};
  // keys: [3:0] start, [7:4] coin, [8] service, [9] up, [10] down, [11] left, [12] right, [15:13] buttons
  always_comb begin
    hit = '0;
    case (ps2_key[7:0])
      8'h16: hit[0] = 1'b1;
      8'h1E: hit[1] = 1'b1;
      8'h26: hit[2] = 1'b1;
      8'h25: hit[3] = 1'b1;
      8'h2E: hit[4] = 1'b1;
      8'h36: hit[5] = 1'b1;
      8'h3D: hit[6] = 1'b1;
      8'h3E: hit[7] = 1'b1;
      8'h46: hit[8] = 1'b1;
      8'h75: hit[9] = 1'b1;
      8'h72: hit[10] = 1'b1;
      8'h6B: hit[11] = 1'b1;
      8'h74: hit[12] = 1'b1;
      8'h14: hit[13] = 1'b1;
      8'h11: hit[14] = 1'b1;
      8'h29: hit[15] = 1'b1;
      default: ;
    endcase
  end
  for (genvar g = 0; g < PLAYERS; g++) begin : g_pl
    localparam int D = g < 2 ? g : 0;
    localparam bit SW = PLAYERS >= 2 && g < 2;
    localparam int O = SW ? 1 - g : g;
    logic [2:0] j;
    logic [15:0] usb_w, src, w;
    // USB words are handed out in order to the players not served by a DB port
    assign j = 3'(g) - (g > 0 ? {2'b0, joy_db_ena[0]} : 3'd0) - (g > 1 ? {2'b0, joy_db_ena[1]} : 3'd0);
    assign usb_w = int'(j) < PLAYERS ? joy_usb[16*j +: 16] : '0;
    assign src = (g < 2 && joy_db_ena[D]) ? joy_db[16*D +: 16] : usb_w;
    assign last_src[g] = src[3+BUTTONS];
    assign w = {src[15:4+BUTTONS], (SW && cfg_flags[4]) ? last_src[O] : src[3+BUTTONS], src[2+BUTTONS:0]};
    assign dir_h[4*g +: 4] = {w[2] | keys[10], w[3] | keys[9], w[0] | keys[12], w[1] | keys[11]};
    for (genvar k = 0; k < BUTTONS; k++) begin : g_b
      assign btn_h[BUTTONS*g + k] = w[4+k] | kbtn[k];
    end
    assign start_h[g] = w[4+BUTTONS] | keys[g];
    assign coin_h[g] = w[5+BUTTONS] | keys[4+g];
    assign pause_h[g] = w[6+BUTTONS];
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      prime <= 1'b1;
      old_state <= 1'b0;
      keys <= '0;
    end else begin
      prime <= 1'b0;
      old_state <= ps2_key[10];
      if (key_ev) keys <= (keys & ~hit) | (hit & {16{ps2_key[9]}});
    end
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      p_dir <= '1;
      p_btn <= '1;
      p_start <= '1;
      p_coin <= '1;
      service <= 1'b1;
      pause_pulse <= 1'b0;
      pause_prev <= 1'b0;
      coin_prev <= '0;
      for (int i = 0; i < PLAYERS; i++) cnt[i] <= '0;
    end else begin
      p_dir <= ~dir_h;
      p_btn <= ~btn_h;
      p_start <= ~start_h;
      service <= ~keys[8];
      pause_prev <= |pause_h;
      pause_pulse <= |pause_h & ~pause_prev;
      coin_prev <= coin_h;
      // a new edge only loads an idle counter, so a running stretch is never extended
      for (int i = 0; i < PLAYERS; i++) begin
        cnt[i] <= cnt[i] != '0 ? cnt[i] - 24'd1 : (coin_h[i] && !coin_prev[i]) ? COIN_MIN : '0;
        p_coin[i] <= ~(coin_h[i] | (cnt[i] != '0));
      end
    end
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dipsw <= '0;
      cfg_flags <= '0;
    end else begin
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == '0 && int'(ioctl_addr[2:0]) < DIP_BANKS)
        dipsw[8*ioctl_addr[2:0] +: 8] <= ioctl_dout;
      if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == '0) cfg_flags <= ioctl_dout;
    end
  end
endmodule

// File: tb/tb_arcade_input_hub.sv
// tb_arcade_input_hub: directed vectors with hand-computed expectations for arcade_input_hub
module tb_arcade_input_hub;
  logic clk_sys = 0, reset = 1;
  logic [10:0] ps2_key = '0;
  logic [31:0] joy_usb = '0, joy_db = '0;
  logic [1:0] joy_db_ena = '0;
  logic ioctl_wr = 0;
  logic [7:0] ioctl_index = '0, ioctl_dout = '0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] p_dir, cfg_flags;
  logic [5:0] p_btn;
  logic [1:0] p_start, p_coin;
  logic service, pause_pulse;
  logic [23:0] dipsw;
  int total = 0, bad = 0, n;
  logic tg = 0;
  always #5 clk_sys = ~clk_sys;
  arcade_input_hub #(.PLAYERS(2), .BUTTONS(3), .DIP_BANKS(3), .COIN_MIN(24'd16)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_usb(joy_usb), .joy_db(joy_db),
    .joy_db_ena(joy_db_ena), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .p_dir(p_dir), .p_btn(p_btn), .p_start(p_start), .p_coin(p_coin),
    .service(service), .pause_pulse(pause_pulse), .dipsw(dipsw), .cfg_flags(cfg_flags)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  task automatic key(input logic prs, input logic [7:0] code);
    tg = ~tg;
    ps2_key = {tg, prs, 1'b0, code};
  endtask
  task automatic wr(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1;
    ioctl_index = idx;
    ioctl_addr = a;
    ioctl_dout = d;
    tick;
    ioctl_wr = 0;
  endtask
  initial begin
    tg = 1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h16};
    repeat (3) tick;
    chk("rst_dir", p_dir, 8'hFF);
    chk("rst_btn", p_btn, 6'h3F);
    chk("rst_start", p_start, 2'b11);
    chk("rst_coin", p_coin, 2'b11);
    chk("rst_svc", service, 1'b1);
    chk("rst_pause", pause_pulse, 1'b0);
    chk("rst_dip", dipsw, 24'h0);
    chk("rst_cfg", cfg_flags, 8'h0);
    reset = 0;
    repeat (3) tick;
    chk("prime_start", p_start, 2'b11);
    chk("prime_dir", p_dir, 8'hFF);
    joy_db_ena = 2'b01;
    joy_usb = 32'h0000_0008;
    joy_db = 32'h0004_0001;
    #1 chk("dir_pre", p_dir, 8'hFF);
    tick; chk("dir_ena01", p_dir, 8'hBD);
    joy_db_ena = 2'b00;
    tick; chk("dir_ena00", p_dir, 8'hFB);
    joy_db_ena = 2'b11;
    tick; chk("dir_ena11", p_dir, 8'h7D);
    joy_db_ena = 2'b10;
    tick; chk("dir_ena10", p_dir, 8'h7B);
    joy_usb = '0;
    joy_db = '0;
    joy_db_ena = '0;
    tick;
    key(1, 8'h75);
    tick; chk("kb_latch", p_dir, 8'hFF);
    key(0, 8'h75);
    tick; chk("kb_up", p_dir, 8'hBB);
    tick; chk("kb_rel", p_dir, 8'hFF);
    key(1, 8'h14);
    tick;
    key(1, 8'h46);
    tick; chk("kb_btn0", p_btn, 6'h36);
    key(1, 8'h1E);
    tick; chk("kb_svc", service, 1'b0);
    tick; chk("kb_start2", p_start, 2'b01);
    key(0, 8'h14);
    tick;
    key(0, 8'h46);
    tick;
    key(0, 8'h1E);
    repeat (2) tick;
    chk("kb_clr_btn", p_btn, 6'h3F);
    chk("kb_clr_svc", service, 1'b1);
    chk("kb_clr_start", p_start, 2'b11);
    key(1, 8'h2E);
    tick; chk("coin_latch", p_coin, 2'b11);
    tick; chk("coin_low", p_coin, 2'b10);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (!p_coin[0]) n++;
      if (i == 4) key(0, 8'h2E);
      tick;
    end
    chk("coin_len", n, 17);
    chk("coin_end", p_coin, 2'b11);
    wr(8'd1, 25'd0, 8'h10);
    chk("cfg_wr", cfg_flags, 8'h10);
    joy_usb = 32'h0040_0000;
    tick; chk("swap_on", p_btn, 6'h3B);
    wr(8'd1, 25'd0, 8'h00);
    wr(8'd1, 25'd1, 8'hFF);
    chk("cfg_addr1", cfg_flags, 8'h00);
    chk("swap_off", p_btn, 6'h1F);
    joy_usb = '0;
    tick;
    wr(8'd254, 25'd0, 8'hA5);
    chk("dip0", dipsw, 24'h0000A5);
    wr(8'd254, 25'd1, 8'h3C);
    wr(8'd254, 25'd2, 8'hFF);
    wr(8'd254, 25'd3, 8'h77);
    wr(8'd254, 25'd8, 8'h11);
    wr(8'd253, 25'd0, 8'h00);
    chk("dip_all", dipsw, 24'hFF3CA5);
    joy_usb = 32'h0000_0200;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      n += int'(pause_pulse);
    end
    chk("pause_held", n, 1);
    joy_usb = '0;
    tick; n += int'(pause_pulse);
    joy_usb = 32'h0000_0200;
    tick; n += int'(pause_pulse);
    joy_usb = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n += int'(pause_pulse);
    end
    chk("pause_cnt", n, 2);
    joy_usb = 32'h0100_0000;
    tick; chk("ucoin", p_coin, 2'b01);
    joy_usb = '0;
    repeat (3) tick;
    chk("ucoin_hold", p_coin, 2'b01);
    #2 reset = 1;
    #1 chk("async_coin", p_coin, 2'b11);
    chk("rst_dip2", dipsw, 24'h0);
    tick;
    reset = 0;
    repeat (3) tick;
    chk("post_rst_coin", p_coin, 2'b11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
